// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit core control sequencer.
// Holds the opcode and FSM state encodings, the branch target table and
// small opcode-classification helpers used by ctrl_fsm.
package cpu_pkg;

   localparam int PC_W  = 8;   // program counter width, wraps modulo 2^PC_W
   localparam int IMM_W = 5;   // immediate field width, zero-extended to 8 bits

   // Opcode field ir[8:5]; every 4-bit code is named so casts stay in range.
   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SHL   = 4'b0001,
      OP_SHR   = 4'b0010,
      OP_MOV   = 4'b0011,
      OP_OR    = 4'b0100,
      OP_XOR   = 4'b0101,
      OP_AND   = 4'b0110,
      OP_ADDI  = 4'b0111,
      OP_BNE   = 4'b1000,
      OP_BEQ   = 4'b1001,
      OP_MOVI  = 4'b1010,
      OP_ILL_B = 4'b1011,
      OP_ILL_C = 4'b1100,
      OP_CMP   = 4'b1101,
      OP_HALT  = 4'b1110,
      OP_NOP   = 4'b1111
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   // Branch targets selected by ir[1:0] when a branch is taken.
   localparam logic [PC_W-1:0] BR_LUT [4] = '{
      PC_W'(8'h10), PC_W'(8'h20), PC_W'(8'h30), PC_W'(8'h00)
   };

   // Opcodes that strobe the register-file write port in WB.
   function automatic logic op_writes(input op_t op);
      return (op inside {OP_ADD, OP_SHL, OP_SHR, OP_MOV,
                         OP_OR, OP_XOR, OP_AND, OP_ADDI, OP_MOVI});
   endfunction

   // Opcodes whose ALU shift/carry output is captured for the next operation.
   function automatic logic op_updates_carry(input op_t op);
      return (op inside {OP_ADD, OP_SHL, OP_SHR, OP_ADDI});
   endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch target lookup: maps the 2-bit branch index to a fixed PC target.
module branch_lut
   import cpu_pkg::*;
(
   input  logic [1:0]      idx,
   output logic [PC_W-1:0] target
);

   // Pure table read of the constant branch targets.
   always_comb target = BR_LUT[idx];

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control sequencer for the 8-bit core: FETCH, DECODE, EXEC and
// WB take one cycle each, so every instruction costs exactly four cycles.
// Optional feature macro ILLEGAL_TRAP_EN: when defined, opcodes 1011/1100
// raise a sticky err and halt; otherwise they behave as nop and err is 0.
module ctrl_fsm
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [8:0]      instr_i,
   input  logic            equal_i,
   input  logic            sc_o_i,
   output logic [PC_W-1:0] pc_o,
   output logic [3:0]      alu_cmd,
   output logic [2:0]      ra_addr,
   output logic [2:0]      rb_addr,
   output logic            use_imm,
   output logic [7:0]      imm_o,
   output logic            sc_i,
   output logic [2:0]      wr_addr,
   output logic            wr_en,
   output logic            done,
   output logic            err
);

   state_t          state_q,   state_d;
   logic [PC_W-1:0] pc_q,      pc_d;
   logic [8:0]      ir_q,      ir_d;
   op_t             op_q,      op_d;
   logic [2:0]      ra_q,      ra_d;
   logic [2:0]      rb_q,      rb_d;
   logic [7:0]      imm_q,     imm_d;
   logic            use_imm_q, use_imm_d;
   logic            write_q,   write_d;
   logic [2:0]      wr_addr_q, wr_addr_d;
   logic            eq_q,      eq_d;
   logic            sc_q,      sc_d;
`ifdef ILLEGAL_TRAP_EN
   logic            err_q,     err_d;
`endif

   op_t             dec_op;
   logic [PC_W-1:0] br_target;

   assign dec_op = op_t'(ir_q[8:5]);

   branch_lut u_branch_lut (
      .idx    (ir_q[1:0]),
      .target (br_target)
   );

   // Next-state, decode and PC sequencing for the four-cycle instruction flow.
   always_comb begin
      // NOTE: every _d gets a hold default first so no path infers a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      op_d      = op_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      imm_d     = imm_q;
      use_imm_d = use_imm_q;
      write_d   = write_q;
      wr_addr_d = wr_addr_q;
      eq_d      = eq_q;
      sc_d      = sc_q;
`ifdef ILLEGAL_TRAP_EN
      err_d     = err_q;
`endif

      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         S_FETCH: begin
            ir_d    = instr_i;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            op_d      = dec_op;
            ra_d      = ir_q[4:2];
            rb_d      = {1'b0, ir_q[1:0]};
            imm_d     = {{(8-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
            use_imm_d = (dec_op == OP_ADDI) || (dec_op == OP_MOVI);
            write_d   = op_writes(dec_op);
            unique case (dec_op)
               OP_MOV:           wr_addr_d = {1'b0, ir_q[1:0]};
               OP_ADDI, OP_MOVI: wr_addr_d = 3'd0;
               default:          wr_addr_d = ir_q[4:2];
            endcase
            state_d = S_EXEC;
         end
         S_EXEC: begin
            eq_d = equal_i;
            if (op_updates_carry(op_q)) sc_d = sc_o_i;
            state_d = S_WB;
         end
         S_WB: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
            unique case (op_q)
               OP_BNE:  if (!eq_q) pc_d = br_target;
               OP_BEQ:  if (eq_q)  pc_d = br_target;
               OP_HALT: begin
                  pc_d    = pc_q;
                  state_d = S_HALT;
               end
`ifdef ILLEGAL_TRAP_EN
               OP_ILL_B, OP_ILL_C: begin
                  pc_d    = pc_q;
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end
`endif
               default: ;
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         op_q      <= OP_NOP;
         ra_q      <= '0;
         rb_q      <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         write_q   <= 1'b0;
         wr_addr_q <= '0;
         eq_q      <= 1'b0;
         sc_q      <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         op_q      <= op_d;
         ra_q      <= ra_d;
         rb_q      <= rb_d;
         imm_q     <= imm_d;
         use_imm_q <= use_imm_d;
         write_q   <= write_d;
         wr_addr_q <= wr_addr_d;
         eq_q      <= eq_d;
         sc_q      <= sc_d;
`ifdef ILLEGAL_TRAP_EN
         err_q     <= err_d;
`endif
      end
   end

   assign pc_o    = pc_q;
   assign alu_cmd = op_q;
   assign ra_addr = ra_q;
   assign rb_addr = rb_q;
   assign use_imm = use_imm_q;
   assign imm_o   = imm_q;
   assign sc_i    = sc_q;
   assign wr_addr = wr_addr_q;
   assign wr_en   = (state_q == S_WB) && write_q;
   assign done    = (state_q == S_HALT);
`ifdef ILLEGAL_TRAP_EN
   assign err     = err_q;
`else
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed testbench for ctrl_fsm: a small program in a behavioural
// instruction memory, stepped cycle by cycle with hand-computed expectations.
module tb_ctrl_fsm;
   import cpu_pkg::*;

   localparam logic [8:0] I_NOP = 9'b1111_00000;

   logic            clk;
   logic            reset;
   logic            start;
   logic [8:0]      instr_i;
   logic            equal_i;
   logic            sc_o_i;
   logic [PC_W-1:0] pc_o;
   logic [3:0]      alu_cmd;
   logic [2:0]      ra_addr;
   logic [2:0]      rb_addr;
   logic            use_imm;
   logic [7:0]      imm_o;
   logic            sc_i;
   logic [2:0]      wr_addr;
   logic            wr_en;
   logic            done;
   logic            err;

   logic [8:0] imem [256];
   int         n_assert = 0;
   int         n_fail   = 0;

   assign instr_i = imem[pc_o];

   ctrl_fsm dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .instr_i (instr_i),
      .equal_i (equal_i),
      .sc_o_i  (sc_o_i),
      .pc_o    (pc_o),
      .alu_cmd (alu_cmd),
      .ra_addr (ra_addr),
      .rb_addr (rb_addr),
      .use_imm (use_imm),
      .imm_o   (imm_o),
      .sc_i    (sc_i),
      .wr_addr (wr_addr),
      .wr_en   (wr_en),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int         budget;
      logic [7:0] halt_pc;

      reset   = 1'b1;
      start   = 1'b0;
      equal_i = 1'b0;
      sc_o_i  = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = I_NOP;
      imem[8'h00] = 9'b1010_00101;   // movi 5
      imem[8'h01] = 9'b0000_001_10;  // add r1, r2
      imem[8'h02] = 9'b1001_011_01;  // beq -> 0x20
      imem[8'h20] = 9'b1001_011_01;  // beq, not taken
      imem[8'h21] = 9'b1000_000_10;  // bne -> 0x30
      imem[8'h30] = 9'b1011_00000;   // illegal
      imem[8'h31] = 9'b1110_00000;   // halt

      // Reset state
      tick(2);
      check("rst_state",   32'(dut.state_q), 32'(S_IDLE));
      check("rst_pc",      pc_o,    8'h00);
      check("rst_wr_en",   wr_en,   1'b0);
      check("rst_done",    done,    1'b0);
      check("rst_err",     err,     1'b0);
      check("rst_sc_i",    sc_i,    1'b0);
      check("rst_use_imm", use_imm, 1'b0);
      check("rst_alu_cmd", alu_cmd, 4'b1111);

      // Reset and start together: reset wins
      start = 1'b1;
      tick(1);
      check("rst_start_state", 32'(dut.state_q), 32'(S_IDLE));

      // movi 5 at pc 0
      reset = 1'b0;
      tick(1);
      start = 1'b0;
      check("start_state", 32'(dut.state_q), 32'(S_FETCH));
      check("start_pc",    pc_o, 8'h00);
      tick(2);
      check("movi_exec_cmd", alu_cmd, 4'b1010);
      tick(1);
      check("movi_wb_wr_en",   wr_en,   1'b1);
      check("movi_wb_wr_addr", wr_addr, 3'd0);
      check("movi_wb_use_imm", use_imm, 1'b1);
      check("movi_wb_imm",     imm_o,   8'h05);
      check("movi_wb_cmd",     alu_cmd, 4'b1010);
      tick(1);
      check("movi_next_pc", pc_o,  8'h01);
      check("movi_wr_off",  wr_en, 1'b0);

      // add r1, r2 with carry out
      tick(2);
      check("add_exec_cmd", alu_cmd, 4'b0000);
      check("add_ra",       ra_addr, 3'd1);
      check("add_rb",       rb_addr, 3'd2);
      check("add_use_imm",  use_imm, 1'b0);
      check("add_wr_early", wr_en,   1'b0);
      sc_o_i = 1'b1;
      tick(1);
      sc_o_i = 1'b0;
      check("add_wb_wr_en",   wr_en,   1'b1);
      check("add_wb_wr_addr", wr_addr, 3'd1);
      check("add_wb_sc_i",    sc_i,    1'b1);
      tick(1);
      check("add_wr_one_cycle", wr_en, 1'b0);
      check("add_pc",           pc_o,  8'h02);
      check("add_sc_held",      sc_i,  1'b1);

      // beq taken at pc 2, with a stray start that must be ignored
      start = 1'b1;
      tick(1);
      check("ign_start_decode", 32'(dut.state_q), 32'(S_DECODE));
      tick(1);
      check("ign_start_exec", 32'(dut.state_q), 32'(S_EXEC));
      start   = 1'b0;
      equal_i = 1'b1;
      tick(1);
      equal_i = 1'b0;
      check("beq_no_write", wr_en, 1'b0);
      tick(1);
      check("beq_taken_pc", pc_o, 8'h20);
      check("beq_sc_kept",  sc_i, 1'b1);

      // beq not taken at 0x20
      tick(4);
      check("beq_not_taken_pc", pc_o, 8'h21);

      // bne taken at 0x21
      tick(4);
      check("bne_taken_pc", pc_o, 8'h30);

      // Illegal 1011 at 0x30
      tick(4);
`ifdef ILLEGAL_TRAP_EN
      check("ill_err",  err,  1'b1);
      check("ill_done", done, 1'b1);
      check("ill_pc",   pc_o, 8'h30);
      halt_pc = 8'h30;
`else
      check("ill_err",  err,  1'b0);
      check("ill_done", done, 1'b0);
      check("ill_pc",   pc_o, 8'h31);
      tick(4);
      halt_pc = 8'h31;
`endif

      // HALT holds for 10 cycles
      for (int i = 0; i < 10; i++) begin
         check("halt_done",  done,  1'b1);
         check("halt_pc",    pc_o,  halt_pc);
         check("halt_wr_en", wr_en, 1'b0);
         tick(1);
      end

      // Restart from HALT
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("restart_pc",    pc_o, 8'h00);
      check("restart_done",  done, 1'b0);
      check("restart_state", 32'(dut.state_q), 32'(S_FETCH));

      // Reset pulsed during EXEC of movi
      tick(2);
      check("mid_exec_state", 32'(dut.state_q), 32'(S_EXEC));
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mid_rst_state",   32'(dut.state_q), 32'(S_IDLE));
      check("mid_rst_pc",      pc_o,    8'h00);
      check("mid_rst_wr_en",   wr_en,   1'b0);
      check("mid_rst_use_imm", use_imm, 1'b0);
      check("mid_rst_cmd",     alu_cmd, 4'b1111);
      check("mid_rst_err",     err,     1'b0);

      // PC wrap: bne to 0x30, nops up to 0xFF, then wrap to 0x00
      imem[8'h00] = 9'b1000_000_10;
      imem[8'h30] = I_NOP;
      imem[8'h31] = I_NOP;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(4);
      check("wrap_branch_pc", pc_o, 8'h30);
      budget = 0;
      while (pc_o !== 8'hFF && budget < 2000) begin
         tick(1);
         budget++;
      end
      check("wrap_reach_ff", pc_o, 8'hFF);
      tick(4);
      check("wrap_pc_zero",  pc_o, 8'h00);
      check("wrap_state",    32'(dut.state_q), 32'(S_FETCH));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
